// File: rtl/seg7_pkg.sv
// Shared types and helpers for the 7-segment scan driver.
package seg7_pkg;

  localparam int unsigned SEG7_DIGITS = 8;

  typedef logic [7:0] seg_pattern_t;
  typedef seg_pattern_t [SEG7_DIGITS-1:0] seg7_bank_t;

  localparam seg_pattern_t SEG_OFF = 8'h00;

  // Patterns are handled active-high internally; this maps them to pin level.
  function automatic seg_pattern_t seg7_polarity(input seg_pattern_t pattern,
                                                 input logic active_low);
    return pattern ^ {8{active_low}};
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-selector to scan-driver bundle: eight digit patterns and page select.
// Optional build macro: SEG7_SCAN_BRIGHTNESS_EN adds the brightness field.
interface seg7_scan_driver_if;
  seg7_pkg::seg_pattern_t r_seg0, r_seg1, r_seg2, r_seg3;
  seg7_pkg::seg_pattern_t l_seg0, l_seg1, l_seg2, l_seg3;
  seg7_pkg::seg_pattern_t page_sel;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
  logic [2:0] brightness;

  modport master (output r_seg0, r_seg1, r_seg2, r_seg3,
                  output l_seg0, l_seg1, l_seg2, l_seg3,
                  output page_sel, brightness);
  modport slave  (input r_seg0, r_seg1, r_seg2, r_seg3,
                  input l_seg0, l_seg1, l_seg2, l_seg3,
                  input page_sel, brightness);
`else
  modport master (output r_seg0, r_seg1, r_seg2, r_seg3,
                  output l_seg0, l_seg1, l_seg2, l_seg3,
                  output page_sel);
  modport slave  (input r_seg0, r_seg1, r_seg2, r_seg3,
                  input l_seg0, l_seg1, l_seg2, l_seg3,
                  input page_sel);
`endif
endinterface

// File: rtl/seg7_scan_driver_slot_timer.sv
// Slot counter and digit index for the scan driver. All outputs are look-ahead:
// they describe the position the timer will hold after the coming clock edge.
module seg7_slot_timer #(
  parameter int unsigned CLK_DIV      = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  localparam int unsigned CW          = $clog2(CLK_DIV)
) (
  input  logic          clock,
  input  logic          reset,
  output logic [2:0]    idx,
  output logic [CW-1:0] cnt,
  output logic          in_blank,
  output logic          frame_end
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CW'(CLK_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx       = idx_d;
  assign cnt       = cnt_d;
  assign in_blank  = (32'(cnt_d) < BLANK_CYCLES);
  assign frame_end = (idx_d == 3'd7) && (cnt_d == CW'(CLK_DIV - 1));

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan driver for eight 7-segment digits plus page LEDs.
// Optional build macro: SEG7_SCAN_BRIGHTNESS_EN enables the brightness PWM window.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 1000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  seg7_scan_driver_if.slave   disp,
  output logic [7:0]          seg_out,
  output logic [7:0]          digit_en,
  output logic [7:0]          led_out,
  output logic                frame_done
);

  localparam int unsigned CW      = $clog2(CLK_DIV);
  localparam seg_pattern_t OFF_LVL = seg7_polarity(SEG_OFF, SEG_ACTIVE_LOW);
`ifdef SEG7_SCAN_BRIGHTNESS_EN
  localparam int unsigned ON_STEP = (CLK_DIV - BLANK_CYCLES) / 8;
`endif

  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic          in_blank;
  logic          frame_end;

  seg7_slot_timer #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .idx       (idx),
    .cnt       (cnt),
    .in_blank  (in_blank),
    .frame_end (frame_end)
  );

  seg7_bank_t   bank_q, bank_d;
  seg_pattern_t page_q, page_d;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
  logic [2:0]   bright_q, bright_d;
`endif
  seg_pattern_t seg_out_q, seg_out_d;
  seg_pattern_t digit_en_q, digit_en_d;
  seg_pattern_t led_out_q, led_out_d;
  logic         frame_done_q, frame_done_d;
  logic         lit;
  seg_pattern_t seg_pre, en_pre;

  // frame_done_q is high exactly during the frame-boundary cycle, so it doubles
  // as the shadow load strobe for that edge.
  always_comb begin
    bank_d = bank_q;
    page_d = page_q;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
    bright_d = bright_q;
`endif
    if (frame_done_q) begin
      bank_d = {disp.l_seg3, disp.l_seg2, disp.l_seg1, disp.l_seg0,
                disp.r_seg3, disp.r_seg2, disp.r_seg1, disp.r_seg0};
      page_d = disp.page_sel;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
      bright_d = disp.brightness;
`endif
    end

    lit = !in_blank;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
    lit = lit && (32'(cnt) < BLANK_CYCLES + ON_STEP * (32'(bright_d) + 32'd1));
`endif
    seg_pre = lit ? bank_d[idx] : SEG_OFF;
    en_pre  = lit ? (8'd1 << idx) : SEG_OFF;

    seg_out_d    = seg7_polarity(seg_pre, SEG_ACTIVE_LOW);
    digit_en_d   = seg7_polarity(en_pre, SEG_ACTIVE_LOW);
    led_out_d    = seg7_polarity(page_d, SEG_ACTIVE_LOW);
    frame_done_d = frame_end;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bank_q       <= '0;
      page_q       <= '0;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
      bright_q     <= '0;
`endif
      seg_out_q    <= OFF_LVL;
      digit_en_q   <= OFF_LVL;
      led_out_q    <= OFF_LVL;
      frame_done_q <= 1'b0;
    end else begin
      bank_q       <= bank_d;
      page_q       <= page_d;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
      bright_q     <= bright_d;
`endif
      seg_out_q    <= seg_out_d;
      digit_en_q   <= digit_en_d;
      led_out_q    <= led_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_out_q;
  assign digit_en   = digit_en_q;
  assign led_out    = led_out_q;
  assign frame_done = frame_done_q;

endmodule
